// File: rtl/seq_signed_multiplier.sv
// Iterative signed multiplier: magnitudes are multiplied by radix-2 shift-add over WIDTH
// cycles and the sign is reapplied. Define SEQ_MULT_ACC_EN for multiply-accumulate mode.
module seq_signed_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
`ifdef SEQ_MULT_ACC_EN
  input  logic                      acc_clr,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] r,
  output logic                      busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic            sign;
  logic [PW-1:0]   p, p_nxt, addend, prod;
  logic [CW-1:0]   cnt;
  logic            last;

  // |x| as an unsigned value; the most negative operand maps to 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] u;
    u = x;
    return x[WIDTH-1] ? (~u + WIDTH'(1)) : u;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] x, input logic s);
    return s ? (~x + PW'(1)) : x;
  endfunction

  assign last   = (cnt == CW'(WIDTH - 1));
  assign addend = b_mag[cnt] ? ({{WIDTH{1'b0}}, a_mag} << cnt) : '0;
  assign p_nxt  = p + addend;
  assign prod   = apply_sign(p_nxt, sign);

`ifdef SEQ_MULT_ACC_EN
  logic          acc_clr_q;
  logic [PW-1:0] acc, acc_nxt;
  assign acc_nxt = (acc_clr_q ? '0 : acc) + prod;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_mag <= '0;
      b_mag <= '0;
      sign  <= 1'b0;
      p     <= '0;
      cnt   <= '0;
      r     <= '0;
`ifdef SEQ_MULT_ACC_EN
      acc_clr_q <= 1'b0;
      acc       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_mag <= mag(a);
            b_mag <= mag(b);
            sign  <= a[WIDTH-1] ^ b[WIDTH-1];
            p     <= '0;
            cnt   <= '0;
`ifdef SEQ_MULT_ACC_EN
            acc_clr_q <= acc_clr;
`endif
          end
        end
        RUN: begin
          p   <= p_nxt;
          cnt <= cnt + CW'(1);
          // Final iteration: the result is registered on the RUN->DONE edge.
          if (last) begin
`ifdef SEQ_MULT_ACC_EN
            acc <= acc_nxt;
            r   <= acc_nxt;
`else
            r   <= prod;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Bench for seq_signed_multiplier (WIDTH=16): directed corners, backpressure, mid-op reset
// and random operands against a plain-arithmetic product/accumulate model.
module tb_seq_signed_multiplier;

  localparam int W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [W-1:0] a, b;
  logic               acc_clr;
  logic               out_valid;
  logic               out_ready;
  logic signed [2*W-1:0] r;
  logic               busy;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] acc_m = '0;

  always #5 clk = ~clk;

  seq_signed_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SEQ_MULT_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product, optionally accumulated, truncated to 2*W bits.
  function automatic logic [31:0] model(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                                        input logic clr);
    longint prodl;
    logic [31:0] p32;
    prodl = longint'(x) * longint'(y);
    p32 = prodl[31:0];
`ifdef SEQ_MULT_ACC_EN
    acc_m = (clr ? 32'd0 : acc_m) + p32;
    return acc_m;
`else
    return p32;
`endif
  endfunction

  task automatic run_op(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                        input logic clr, input int stall);
    logic [31:0] exp, held;
    int cyc;
    exp = model(x, y, clr);
    @(negedge clk);
    a = x; b = y; acc_clr = clr; in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    a = W'($urandom); b = W'($urandom); acc_clr = 1'($urandom);
    check("busy_run", {31'd0, busy}, 32'd1);
    check("in_ready_run", {31'd0, in_ready}, 32'd0);
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      a = W'($urandom); b = W'($urandom);
    end
    check("latency", cyc, W + 1);
    check("result", r, exp);
    held = r;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_r_stable", r, held);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("in_ready_after", {31'd0, in_ready}, 32'd1);
    check("out_valid_after", {31'd0, out_valid}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; acc_clr = 1'b0;
    a = 16'sd5; b = 16'sd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_r", r, 32'd0);
    in_valid = 1'b0; rst_n = 1'b1;
    acc_m = '0;

    run_op(16'sd3, -16'sd5, 1'b1, 0);
    run_op(-16'sd32768, -16'sd32768, 1'b1, 0);
    run_op(-16'sd32768, 16'sd32767, 1'b1, 0);
    run_op(16'sd0, -16'sd1, 1'b1, 0);
    run_op(-16'sd1, -16'sd1, 1'b1, 0);
    run_op(16'sd1234, -16'sd321, 1'b1, 5);

    // Reset asserted during RUN cycle 8 discards the operation.
    @(negedge clk);
    a = 16'sd100; b = 16'sd200; in_valid = 1'b1; acc_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = '0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_r", r, 32'd0);
    run_op(16'sd7, 16'sd9, 1'b0, 0);

`ifdef SEQ_MULT_ACC_EN
    run_op(16'sd2, 16'sd3, 1'b1, 0);
    check("acc_first", r, 32'd6);
    run_op(-16'sd4, 16'sd5, 1'b0, 0);
    check("acc_second", r, 32'hFFFF_FFF2);
`endif

    for (int n = 0; n < 20; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
